// File: rtl/key_pkg.sv
// Shared types and default timing constants for the key event generator.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_st_t;

  localparam int unsigned KEY_LONG_CYC   = 1000;
  localparam int unsigned KEY_REPEAT_CYC = 200;
  localparam int unsigned KEY_CNT_W      = 16;

endpackage

// File: rtl/key_event_gen.sv
// Turns the debounced active-low key level into press/release/long/repeat pulses
// and keeps a wrapping press counter.
module key_event_gen
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC   = KEY_LONG_CYC,
  parameter int unsigned REPEAT_CYC = KEY_REPEAT_CYC,
  parameter int unsigned CNT_W      = KEY_CNT_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_In,
  output logic       Press_P,
  output logic       Release_P,
  output logic       Long_P,
  output logic       Repeat_P,
  output logic       Key_Held,
  output logic [7:0] Press_Cnt
);

  localparam longint unsigned TMR_MAX = (64'd1 << CNT_W) - 64'd1;

  if (LONG_CYC < 2 || REPEAT_CYC < 1 ||
      LONG_CYC > TMR_MAX || REPEAT_CYC > TMR_MAX) begin : g_bad_param
    $error("key_event_gen: illegal LONG_CYC/REPEAT_CYC for CNT_W");
  end

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  key_st_t          state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [7:0]       cnt_d;
  logic             press_d, release_d, long_d, repeat_d;

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = Press_Cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!KEY_In) begin
          state_d = PRESSED;
          press_d = 1'b1;
          tmr_d   = '0;
          cnt_d   = Press_Cnt + 8'd1;
        end
      end
      PRESSED: begin
        // Release is checked first so it wins over a same-cycle threshold match.
        if (KEY_In) begin
          state_d   = IDLE;
          release_d = 1'b1;
          tmr_d     = '0;
        end else if (tmr_q == LONG_LAST) begin
          state_d = LONG;
          long_d  = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LONG: begin
        if (KEY_In) begin
          state_d   = IDLE;
          release_d = 1'b1;
          tmr_d     = '0;
        end else if (tmr_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      Press_P   <= 1'b0;
      Release_P <= 1'b0;
      Long_P    <= 1'b0;
      Repeat_P  <= 1'b0;
      Key_Held  <= 1'b0;
      Press_Cnt <= 8'd0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      Press_P   <= press_d;
      Release_P <= release_d;
      Long_P    <= long_d;
      Repeat_P  <= repeat_d;
      Key_Held  <= (state_d != IDLE);
      Press_Cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with LONG_CYC=8, REPEAT_CYC=3.
module tb_key_event_gen;

  logic       CLK;
  logic       RST;
  logic       KEY_In;
  logic       Press_P, Release_P, Long_P, Repeat_P, Key_Held;
  logic [7:0] Press_Cnt;
  logic [4:0] ev;

  int n_checks;
  int n_fail;

  key_event_gen #(
    .LONG_CYC  (8),
    .REPEAT_CYC(3),
    .CNT_W     (16)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .KEY_In   (KEY_In),
    .Press_P  (Press_P),
    .Release_P(Release_P),
    .Long_P   (Long_P),
    .Repeat_P (Repeat_P),
    .Key_Held (Key_Held),
    .Press_Cnt(Press_Cnt)
  );

  // Event vector: {press, release, long, repeat, held}
  assign ev = {Press_P, Release_P, Long_P, Repeat_P, Key_Held};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive the key for one cycle, then check the registered outputs after the edge.
  task automatic cyc(input logic key, input logic [4:0] exp, input string tag);
    @(negedge CLK);
    KEY_In = key;
    @(posedge CLK);
    #1;
    check(tag, {27'd0, ev}, {27'd0, exp});
  endtask

  // Assert reset mid-cycle, confirm cleared outputs across one edge, release mid-cycle.
  task automatic do_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    check({tag, "_ev"}, {27'd0, ev}, 32'd0);
    check({tag, "_cnt"}, {24'd0, Press_Cnt}, 32'd0);
    @(posedge CLK);
    #1;
    check({tag, "_ev_hold"}, {27'd0, ev}, 32'd0);
    #2;
    RST = 1'b0;
  endtask

  initial begin
    logic [4:0] exp;
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b0;
    KEY_In   = 1'b1;

    // Reset then idle
    @(posedge CLK);
    #1;
    do_reset("rst0");
    for (int i = 0; i < 20; i++) cyc(1'b1, 5'b00000, "idle");
    check("idle_cnt", {24'd0, Press_Cnt}, 32'd0);

    // Short press: 4 cycles low
    cyc(1'b0, 5'b10001, "short_press");
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'b00001, "short_hold");
    cyc(1'b1, 5'b01000, "short_release");
    cyc(1'b1, 5'b00000, "short_idle");
    check("short_cnt", {24'd0, Press_Cnt}, 32'd1);

    // Long press with repeats; release lands on a repeat match and must win
    for (int i = 1; i <= 20; i++) begin
      exp = 5'b00001;
      if (i == 1) exp = 5'b10001;
      if (i == 9) exp = 5'b00101;
      if (i == 12 || i == 15 || i == 18) exp = 5'b00011;
      cyc(1'b0, exp, "long_seq");
    end
    cyc(1'b1, 5'b01000, "long_release");
    check("long_cnt", {24'd0, Press_Cnt}, 32'd2);

    // Release on the long threshold cycle: release only
    cyc(1'b0, 5'b10001, "thr_press");
    for (int i = 0; i < 7; i++) cyc(1'b0, 5'b00001, "thr_hold");
    cyc(1'b1, 5'b01000, "thr_release");
    cyc(1'b1, 5'b00000, "thr_idle");
    check("thr_cnt", {24'd0, Press_Cnt}, 32'd3);

    // Counter wrap: 256 one-cycle presses with the key toggling every cycle
    do_reset("rst1");
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 5'b10001, "wrap_press");
      check("wrap_cnt", {24'd0, Press_Cnt}, (i + 1) % 256);
      cyc(1'b1, 5'b01000, "wrap_release");
    end
    check("wrap_final", {24'd0, Press_Cnt}, 32'd0);

    // Reset mid-hold while in LONG, then restart with key still held
    cyc(1'b0, 5'b10001, "mh_press");
    for (int i = 2; i <= 10; i++) cyc(1'b0, (i == 9) ? 5'b00101 : 5'b00001, "mh_hold");
    do_reset("rst2");
    cyc(1'b0, 5'b10001, "mh_repress");
    check("mh_cnt", {24'd0, Press_Cnt}, 32'd1);
    cyc(1'b1, 5'b01000, "mh_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
